// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg: default sizing and legal parameter limits for elastic_pipeline
package elastic_pipeline_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;
   localparam int MIN_WIDTH = 1;
   localparam int MAX_WIDTH = 64;
   localparam int MIN_DEPTH = 1;
   localparam int MAX_DEPTH = 16;
endpackage

// File: rtl/elastic_pipeline_stage.sv
// pipe_stage: one valid/data register pair with load, hold and valid-clear control
module pipe_stage
   import elastic_pipeline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);
   // clear drops only the valid bit; the data register keeps its stale word
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else begin
         q_valid <= clear ? 1'b0 : (load ? d_valid : q_valid);
         if (load && !clear) q_data <= d_data;
      end
endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapse and flush
module elastic_pipeline
   import elastic_pipeline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic [DEPTH*WIDTH-1:0]     stage_data,
   output logic [DEPTH-1:0]           stage_valid,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int OW = $clog2(DEPTH + 1);
   logic [DEPTH-1:0]            sv;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0][WIDTH-1:0] sd;
   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_param
      $error("elastic_pipeline: WIDTH or DEPTH out of legal range");
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             pv;
      logic [WIDTH-1:0] pd;
      // a stage can move when any stage downstream of it, or the sink, has room
      assign rdy[i] = out_ready | ~(&sv[DEPTH-1:i]);
      if (i == 0) begin : g_head
         assign pv = in_valid;
         assign pd = in_data;
      end else begin : g_body
         assign pv = sv[i-1];
         assign pd = sd[i-1];
      end
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .load    (rdy[i]),
         .clear   (flush),
         .d_valid (pv),
         .d_data  (pd),
         .q_valid (sv[i]),
         .q_data  (sd[i])
      );
   end
   assign in_ready    = rdy[0] & ~flush;
   assign out_valid   = sv[DEPTH-1];
   assign out_data    = sd[DEPTH-1];
   assign stage_valid = sv;
   assign stage_data  = sd;
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(sv[i]);
   end
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and randomized scoreboard bench for elastic_pipeline
module tb_elastic_pipeline;
   import elastic_pipeline_pkg::*;
   int checks = 0;
   int errors = 0;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   logic        rst, iv, ir, ov, ordy, fl;
   logic [7:0]  id, od;
   logic [23:0] sd;
   logic [2:0]  sv;
   logic [1:0]  occ;
   logic [7:0]  q[$];
   logic [3:0]  sw_done = '0;

   elastic_pipeline #(.WIDTH(8), .DEPTH(3)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .flush(fl),
      .stage_data(sd), .stage_valid(sv), .occupancy(occ)
   );

   always @(negedge clk)
      if (rst) q.delete();
      else begin
         if (ov && ordy) begin
            check("pop_expected", 64'(q.size() != 0), 1);
            if (q.size() != 0) check("out_data", od, q.pop_front());
         end
         if (fl) q.delete();
         if (iv && ir) q.push_back(id);
         check("occ_popcount", occ, $countones(sv));
      end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      ordy = 1'b1;
      iv = 1'b0;
      for (int t = 0; t < 20 && occ != 0; t++) step();
      check("drain", occ, 0);
   endtask

   initial begin
      rst = 1'b1; iv = 1'b0; id = '0; ordy = 1'b1; fl = 1'b0;
      #3;
      check("rst_out_valid", ov, 0);
      check("rst_occ", occ, 0);
      check("rst_stage_valid", sv, 0);
      check("rst_stage_data", sd, 0);
      check("rst_out_data", od, 0);
      check("rst_in_ready", ir, 1);
      fl = 1'b1;
      #1 check("rst_in_ready_flush", ir, 0);
      fl = 1'b0;
      step(); step();
      rst = 1'b0;
      // streaming: word c+1 offered in cycle c, emerges in cycle c+3
      for (int c = 0; c < 13; c++) begin
         iv = c < 10;
         id = 8'(c + 1);
         @(negedge clk);
         check("stream_in_ready", ir, 1);
         check("stream_out_valid", ov, c >= 3);
         if (c >= 3) check("stream_out_data", od, 64'(c - 2));
         step();
      end
      iv = 1'b0;
      // backpressure
      ordy = 1'b0;
      iv = 1'b1;
      id = 8'hA1; step();
      id = 8'hA2; step();
      id = 8'hA3; step();
      id = 8'hEE;
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         check("bp_in_ready", ir, 0);
         check("bp_occ", occ, 3);
         check("bp_stage_valid", sv, 3'b111);
         check("bp_stage_data", sd, 24'hA1A2A3);
         check("bp_out_data", od, 8'hA1);
         step();
      end
      ordy = 1'b1;
      id = 8'hA4;
      @(negedge clk);
      check("bp_release_in_ready", ir, 1);
      check("bp_release_out", od, 8'hA1);
      step();
      drain();
      // bubble collapse
      ordy = 1'b0;
      iv = 1'b1; id = 8'h11; step();
      iv = 1'b0; step();
      iv = 1'b1; id = 8'h22; step();
      iv = 1'b0; step();
      @(negedge clk);
      check("bubble_stage_valid", sv, 3'b110);
      check("bubble_occ", occ, 2);
      check("bubble_data", sd[23:8], 16'h1122);
      step();
      drain();
      // flush while full, with a competing input word
      ordy = 1'b0;
      iv = 1'b1;
      id = 8'hB1; step();
      id = 8'hB2; step();
      id = 8'hB3; step();
      fl = 1'b1; id = 8'h55;
      @(negedge clk);
      check("flush_in_ready", ir, 0);
      step();
      fl = 1'b0; iv = 1'b0;
      @(negedge clk);
      check("flush_occ", occ, 0);
      check("flush_out_valid", ov, 0);
      check("flush_data_kept", sd, 24'hB1B2B3);
      ordy = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         check("flush_no_emerge", ov, 0);
         step();
      end
      // flush with a simultaneous pop: the popped word is delivered
      ordy = 1'b0;
      iv = 1'b1;
      id = 8'hC1; step();
      id = 8'hC2; step();
      id = 8'hC3; step();
      iv = 1'b0; ordy = 1'b1; fl = 1'b1;
      @(negedge clk);
      check("flush_pop_valid", ov, 1);
      check("flush_pop_data", od, 8'hC1);
      step();
      fl = 1'b0;
      @(negedge clk);
      check("flush_pop_occ", occ, 0);
      step();
      // asynchronous reset mid-stream
      ordy = 1'b0;
      iv = 1'b1;
      id = 8'h61; step();
      id = 8'h62; step();
      iv = 1'b0;
      @(negedge clk);
      check("pre_rst_occ", occ, 2);
      #2 rst = 1'b1;
      #1;
      check("arst_occ", occ, 0);
      check("arst_out_valid", ov, 0);
      check("arst_stage_valid", sv, 0);
      check("arst_stage_data", sd, 0);
      check("arst_out_data", od, 0);
      check("arst_in_ready", ir, 1);
      step(); step();
      rst = 1'b0;
      ordy = 1'b1;
      iv = 1'b1; id = 8'h77;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_rst_valid", ov, c == 3);
         if (c == 3) check("post_rst_data", od, 8'h77);
         step();
         iv = 1'b0;
      end
      for (int t = 0; t < 2000 && sw_done != 4'hF; t++) step();
      check("sweep_done", sw_done, 4'hF);
      check("sb_empty", 64'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // parameter sweep: DEPTH in {1,16} x WIDTH in {1,32}, random valid/ready
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int D  = (g % 2) ? 16 : 1;
      localparam int W  = (g / 2) ? 32 : 1;
      localparam int OW = $clog2(D + 1);
      logic            srst, siv, sir, sov, sordy;
      logic [W-1:0]    sid, sod;
      logic [D*W-1:0]  ssd;
      logic [D-1:0]    ssv;
      logic [OW-1:0]   socc;
      logic [W-1:0]    sq[$];
      elastic_pipeline #(.WIDTH(W), .DEPTH(D)) u_sw (
         .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir), .in_data(sid),
         .out_valid(sov), .out_ready(sordy), .out_data(sod), .flush(1'b0),
         .stage_data(ssd), .stage_valid(ssv), .occupancy(socc)
      );
      always @(negedge clk)
         if (srst) sq.delete();
         else begin
            if (sov && sordy) begin
               check("sw_pop_expected", 64'(sq.size() != 0), 1);
               if (sq.size() != 0) check("sw_data", 64'(sod), 64'(sq.pop_front()));
            end
            if (siv && sir) sq.push_back(sid);
            check("sw_occ_le_depth", 64'(socc <= OW'(D)), 1);
            check("sw_occ_popcount", 64'(socc), 64'($countones(ssv)));
         end
      initial begin
         srst = 1'b1; siv = 1'b0; sid = '0; sordy = 1'b0;
         repeat (2) @(posedge clk);
         #1 srst = 1'b0;
         for (int n = 0; n < 400; n++) begin
            siv = 1'($urandom_range(0, 1));
            sid = W'($urandom);
            sordy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         siv = 1'b0;
         sordy = 1'b1;
         repeat (D + 4) begin
            @(posedge clk);
            #1;
         end
         check("sw_drained", 64'(sq.size()), 0);
         sw_done[g] = 1'b1;
      end
   end
endmodule

// File: doc/elastic_pipeline.md
ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits; legal range 1 to 64.
REQ-002 Parameter: DEPTH, 3, number of register stages; legal range 1 to 16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  last stage holds a valid word.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  WIDTH  last-stage payload.
REQ-011 flush  input  1  synchronous discard of all in-flight words.
REQ-012 stage_data  output  DEPTH*WIDTH  per-stage data taps; stage 0 in bits [WIDTH-1:0].
REQ-013 stage_valid  output  DEPTH  per-stage valid taps; bit 0 is the stage fed by in_data.
REQ-014 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 Each stage SHALL hold one register pair: valid bit and WIDTH-bit data.
REQ-016 Stage i SHALL be ready when it is empty or stage i+1 is ready. The last stage SHALL be ready when it is empty or out_ready=1.
REQ-017 in_ready SHALL equal stage-0 ready AND NOT flush. This is a combinational path from out_ready; no combinational path from in_valid to any output.
REQ-018 A transfer SHALL occur on an edge where valid and ready are both 1 at that boundary. A ready stage SHALL load the previous stage's data and valid. Stage 0 SHALL load in_data and in_valid.
REQ-019 A non-ready (stalled) stage SHALL hold its data and valid unchanged.
REQ-020 Latency SHALL be exactly DEPTH cycles from input acceptance to out_valid with no stall. Throughput SHALL be one word per cycle.
REQ-021 Words SHALL exit in acceptance order. No word SHALL be duplicated or dropped except by flush or reset.
REQ-022 Full with out_ready=1: in_ready SHALL be 1, and a simultaneous push and pop SHALL both complete with occupancy unchanged.
REQ-023 Full with out_ready=0: in_ready SHALL be 0 and all stages SHALL hold.
REQ-024 Bubbles SHALL collapse: an empty stage accepts from upstream even while downstream stalls.
REQ-025 flush=1 at an edge SHALL clear every valid bit, and data registers SHALL keep their value. An in_valid word in the same cycle SHALL be discarded. out_valid may be 1 during the flush cycle; a pop in that cycle counts as delivered.
REQ-026 occupancy SHALL equal the popcount of stage_valid, as a combinational function of the registered valid bits.
REQ-027 out_data and stage_data SHALL reflect register contents only; values in invalid stages are stale and carry no meaning.

Reset
REQ-028 Asserting rst SHALL immediately clear all valid bits and all data registers to 0, mid-transfer included.
REQ-029 During reset: out_valid=0, occupancy=0, stage_valid=0, stage_data=0, out_data=0. in_ready SHALL be 1 unless flush=1.
REQ-030 The first acceptance SHALL occur on the first rising edge after rst deasserts with in_valid=1.

Structure
REQ-031 Package elastic_pipeline_pkg SHALL hold the default WIDTH/DEPTH constants and the legal-range limits. Elaboration SHALL fail on an out-of-range parameter.
REQ-032 Sub-module pipe_stage (one valid/data register pair with hold/load/clear control) SHALL be instantiated DEPTH times via generate.

Verification
REQ-033 Streaming, WIDTH=8, DEPTH=3, out_ready=1: push 0x01..0x0A on consecutive cycles -> 0x01 appears at out_valid 3 cycles after acceptance, then one word per cycle, in order.
REQ-034 Backpressure: fill with 0xA1,0xA2,0xA3, hold out_ready=0 -> in_ready=0, occupancy=3, taps stable. Release -> 0xA1,0xA2,0xA3 out in order, and a concurrent push of 0xA4 is accepted.
REQ-035 Bubble collapse: push 0x11, idle 1 cycle, push 0x22, out_ready=0 -> both words pack into stages 2 and 1 with occupancy=2.
REQ-036 Flush: occupancy=3, assert flush for 1 cycle with in_valid=1 and in_data=0x55 -> next cycle occupancy=0, out_valid=0, and 0x55 never emerges.
REQ-037 Reset mid-stream: assert rst asynchronously between edges with occupancy=2 -> outputs zero immediately. After release, push 0x77 -> 0x77 emerges after 3 cycles.
REQ-038 Parameter sweep: DEPTH=1 and DEPTH=16, WIDTH=1 and WIDTH=32, random valid/ready at 50% -> a scoreboard shows in-order, lossless delivery and occupancy never exceeds DEPTH.
